// File: rtl/alarm_fsm_core.sv
// rtl/alarm_fsm_core.sv - elapsed-seconds alarm state machine for the egg timer
//
// Counts rising edges of the seconds clock while enabled, from 0 up to a
// programmable limit, then raises a sticky alarm flag held until reset.
//
// Ports:
//   sec_clk - seconds clock; every state change happens on its rising edge
//   rst     - synchronous, active-high reset (priority over all inputs)
//   enable  - level-sensitive run/pause control
//   max     - alarm limit in seconds, unsigned, sampled every cycle
//   count   - elapsed seconds, registered (feeds the display)
//   alarm   - alarm flag, registered, sticky until reset (drives the buzzer)

module alarm_fsm_core #(
  parameter int SIZE = 4
) (
  input  logic            sec_clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [SIZE-1:0] max,
  output logic [SIZE-1:0] count,
  output logic            alarm
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    ALARM    = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge sec_clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      alarm <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            if (max == '0) begin
              // zero limit: fire on the first enabled edge without counting
              state <= ALARM;
              alarm <= 1'b1;
            end else begin
              state <= COUNTING;
              count <= {{(SIZE-1){1'b0}}, 1'b1};
            end
          end
        end

        COUNTING: begin
          if (enable) begin
            // >= rather than == so that lowering max below count mid-run
            // still fires; count stops at max, so it can never wrap
            if (count >= max) begin
              state <= ALARM;
              alarm <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end

        ALARM: begin
          // sticky: only rst leaves this state
          alarm <= 1'b1;
        end

        default: begin
          // unreachable encoding: recover to a clean idle
          state <= IDLE;
          count <= '0;
          alarm <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_fsm_core.sv
// tb/tb_alarm_fsm_core.sv - directed self-checking bench for alarm_fsm_core

module tb_alarm_fsm_core;

  logic       sec_clk;
  logic       rst;
  logic       enable;
  logic [3:0] max;
  logic [3:0] count;
  logic       alarm;

  int checks;
  int errors;

  alarm_fsm_core #(.SIZE(4)) dut (
    .sec_clk (sec_clk),
    .rst     (rst),
    .enable  (enable),
    .max     (max),
    .count   (count),
    .alarm   (alarm)
  );

  initial sec_clk = 1'b0;
  always #5 sec_clk = ~sec_clk;

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge sec_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    enable = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    max = 4'd0;
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", count);
    end
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_alarm: got %0b expected 0", alarm);
    end
    max = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (count !== 4'd0 || alarm !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold[%0d]: got count=%0d alarm=%0b expected count=0 alarm=0", i, count, alarm);
      end
    end
  endtask

  task automatic test_nominal();
    logic [3:0] exp_count;
    logic       exp_alarm;
    apply_reset();
    max = 4'd5;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp_count = (i <= 5) ? 4'(i) : 4'd5;
      exp_alarm = (i == 6);
      checks++;
      if (count !== exp_count || alarm !== exp_alarm) begin
        errors++;
        $display("FAIL nominal_edge%0d: got count=%0d alarm=%0b expected count=%0d alarm=%0b", i, count, alarm, exp_count, exp_alarm);
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (count !== 4'd5 || alarm !== 1'b1) begin
        errors++;
        $display("FAIL nominal_sticky[%0d]: got count=%0d alarm=%0b expected count=5 alarm=1", i, count, alarm);
      end
    end
    max = 4'd0;
    enable = 1'b1;
    tick();
    checks++;
    if (count !== 4'd5 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_ignores_inputs: got count=%0d alarm=%0b expected count=5 alarm=1", count, alarm);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    enable = 1'b0;
    checks++;
    if (count !== 4'd0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_from_alarm: got count=%0d alarm=%0b expected count=0 alarm=0", count, alarm);
    end
  endtask

  task automatic test_pause();
    apply_reset();
    max = 4'd5;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (count !== 4'd3 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL pause_before: got count=%0d alarm=%0b expected count=3 alarm=0", count, alarm);
    end
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (count !== 4'd3 || alarm !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got count=%0d alarm=%0b expected count=3 alarm=0", i, count, alarm);
      end
    end
    enable = 1'b1;
    tick();
    checks++;
    if (count !== 4'd4 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume1: got count=%0d alarm=%0b expected count=4 alarm=0", count, alarm);
    end
    tick();
    checks++;
    if (count !== 4'd5 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL pause_resume2: got count=%0d alarm=%0b expected count=5 alarm=0", count, alarm);
    end
    tick();
    checks++;
    if (count !== 4'd5 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL pause_resume3: got count=%0d alarm=%0b expected count=5 alarm=1", count, alarm);
    end
  endtask

  task automatic test_zero_limit();
    apply_reset();
    max = 4'd0;
    enable = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL zero_limit: got count=%0d alarm=%0b expected count=0 alarm=1", count, alarm);
    end
    max = 4'd7;
    tick();
    checks++;
    if (count !== 4'd0 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL zero_limit_hold: got count=%0d alarm=%0b expected count=0 alarm=1", count, alarm);
    end
  endtask

  task automatic test_full_range();
    apply_reset();
    max = 4'd15;
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (count !== 4'(i) || alarm !== 1'b0) begin
        errors++;
        $display("FAIL full_range_edge%0d: got count=%0d alarm=%0b expected count=%0d alarm=0", i, count, alarm, i);
      end
    end
    tick();
    checks++;
    if (count !== 4'd15 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL full_range_edge16: got count=%0d alarm=%0b expected count=15 alarm=1", count, alarm);
    end
    tick();
    checks++;
    if (count !== 4'd15 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL full_range_no_wrap: got count=%0d alarm=%0b expected count=15 alarm=1", count, alarm);
    end
  endtask

  task automatic test_limit_change();
    apply_reset();
    max = 4'd9;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (count !== 4'd4 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL limit_change_pre: got count=%0d alarm=%0b expected count=4 alarm=0", count, alarm);
    end
    max = 4'd2;
    tick();
    checks++;
    if (count !== 4'd4 || alarm !== 1'b1) begin
      errors++;
      $display("FAIL limit_change_fire: got count=%0d alarm=%0b expected count=4 alarm=1", count, alarm);
    end
  endtask

  task automatic test_reset_midcount();
    apply_reset();
    max = 4'd5;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (count !== 4'd3) begin
      errors++;
      $display("FAIL midreset_pre: got count=%0d expected 3", count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (count !== 4'd0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got count=%0d alarm=%0b expected count=0 alarm=0", count, alarm);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (count !== 4'd1 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL midreset_restart: got count=%0d alarm=%0b expected count=1 alarm=0", count, alarm);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    enable = 1'b0;
    max = 4'd0;
    #2;
    test_reset();
    test_nominal();
    test_pause();
    test_zero_limit();
    test_full_range();
    test_limit_change();
    test_reset_midcount();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
